// File: rtl/dsp_mac_pkg.sv
// Shared definitions for the dot-product MAC.
//   sum_width : exact width of the lane-product reduction
//   cfg_ok    : legality of a parameter set (checked at elaboration)
//   ext64     : sign/zero-extend a w-bit value held in a 64-bit container
//   sat_add   : saturating add of two w-bit values held in 64-bit containers
package dsp_mac_pkg;

  // Widest accumulator supported; leaves headroom in the 64-bit containers.
  localparam int MAX_ACC_W = 62;

  typedef struct packed {
    logic        ovf;
    logic [63:0] val;
  } sat_res_t;

  function automatic int sum_width(input int num_lanes, input int data_w);
    return 2 * data_w + $clog2(num_lanes);
  endfunction

  function automatic bit cfg_ok(input int num_lanes, input int data_w, input int acc_w);
    return (num_lanes >= 1) && (num_lanes <= 16) &&
           ((num_lanes & (num_lanes - 1)) == 0) &&
           (data_w >= 1) &&
           (acc_w >= sum_width(num_lanes, data_w)) &&
           (acc_w <= MAX_ACC_W);
  endfunction

  function automatic logic [63:0] ext64(input logic [63:0] x, input int w, input bit sgn);
    logic [63:0] r;
    r = x;
    for (int k = 0; k < 64; k++) begin
      if (k >= w) r[k] = sgn & x[w-1];
    end
    return r;
  endfunction

  // Operands must already be extended to 64 bits; the 64-bit sum cannot wrap
  // because both operands are at most MAX_ACC_W bits wide.
  function automatic sat_res_t sat_add(input logic [63:0] a, input logic [63:0] b,
                                       input int w, input bit sgn);
    sat_res_t          r;
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sum = $signed(a) + $signed(b);
    if (sgn) begin
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
    end else begin
      hi = (64'sd1 <<< w) - 64'sd1;
      lo = 64'sd0;
    end
    r.ovf = (sum > hi) || (sum < lo);
    if (sum > hi)      r.val = hi;
    else if (sum < lo) r.val = lo;
    else               r.val = sum;
    return r;
  endfunction

endpackage

// File: rtl/dsp_mac_dotprod_acc_reduce.sv
// Stages S1-S2 of the dot-product MAC: per-lane products (S1) and their
// exact sum (S2). Everything advances only when en_i is high.
//   en_i              pipeline advance (low while output is stalled)
//   valid_i/clear_i/last_i  beat tags travelling alongside the data
//   dataa_i/datab_i   packed lane operands, lane i at [i*DATA_W +: DATA_W]
//   valid_o/clear_o/last_o  tags aligned with sum_o
//   sum_o             SW-bit sum of lane products, sign/zero-extended
module dsp_mac_reduce
  import dsp_mac_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int DATA_W    = 8,
  parameter bit SIGNED    = 1'b1,
  parameter int SW        = 2 * DATA_W + $clog2(NUM_LANES)
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          en_i,
  input  logic                          valid_i,
  input  logic                          clear_i,
  input  logic                          last_i,
  input  logic [NUM_LANES*DATA_W-1:0]   dataa_i,
  input  logic [NUM_LANES*DATA_W-1:0]   datab_i,
  output logic                          valid_o,
  output logic                          clear_o,
  output logic                          last_o,
  output logic [SW-1:0]                 sum_o
);

  logic [SW-1:0] prod_d [NUM_LANES];
  logic [SW-1:0] prod_q [NUM_LANES];
  logic          v1_q, c1_q, l1_q;
  logic [SW-1:0] sum_d;
  logic [SW-1:0] sum_q;
  logic          v2_q, c2_q, l2_q;

  function automatic logic [SW-1:0] ext_op(input logic [DATA_W-1:0] x);
    logic [SW-1:0] r;
    r = '0;
    r[DATA_W-1:0] = x;
    for (int k = DATA_W; k < SW; k++) r[k] = SIGNED & x[DATA_W-1];
    return r;
  endfunction

  // Multiplying the operands already extended to SW bits gives the exact
  // product extended to SW bits, since the true product fits in 2*DATA_W.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      prod_d[i] = ext_op(dataa_i[i*DATA_W +: DATA_W]) * ext_op(datab_i[i*DATA_W +: DATA_W]);
    end
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < NUM_LANES; i++) sum_d = sum_d + prod_q[i];
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_LANES; i++) prod_q[i] <= '0;
      v1_q  <= 1'b0;
      c1_q  <= 1'b0;
      l1_q  <= 1'b0;
      sum_q <= '0;
      v2_q  <= 1'b0;
      c2_q  <= 1'b0;
      l2_q  <= 1'b0;
    end else if (en_i) begin
      for (int i = 0; i < NUM_LANES; i++) prod_q[i] <= prod_d[i];
      v1_q  <= valid_i;
      c1_q  <= clear_i;
      l1_q  <= last_i;
      sum_q <= sum_d;
      v2_q  <= v1_q;
      c2_q  <= c1_q;
      l2_q  <= l1_q;
    end
  end

  assign valid_o = v2_q;
  assign clear_o = c2_q;
  assign last_o  = l2_q;
  assign sum_o   = sum_q;

endmodule

// File: rtl/dsp_mac_dotprod_acc.sv
// Pipelined dot-product MAC with run-length accumulation and saturation.
// S1/S2 live in dsp_mac_reduce; this file holds S3 (accumulator and output
// register) and the stall logic.
//   clock, resetn          clock and async active-low reset
//   ivalid/oready          input handshake, beat transfers on ivalid && oready
//   dataa/datab            packed lane operands
//   iclear/ilast           beat starts / ends an accumulation
//   ovalid/iready          output handshake
//   result/osat            accumulated dot product and sticky saturation flag
module dsp_mac_dotprod_acc
  import dsp_mac_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 32,
  parameter bit SIGNED    = 1'b1
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic                        ivalid,
  output logic                        oready,
  input  logic [NUM_LANES*DATA_W-1:0] dataa,
  input  logic [NUM_LANES*DATA_W-1:0] datab,
  input  logic                        iclear,
  input  logic                        ilast,
  output logic                        ovalid,
  input  logic                        iready,
  output logic [ACC_W-1:0]            result,
  output logic                        osat
);

  localparam int SW = sum_width(NUM_LANES, DATA_W);

  if (!cfg_ok(NUM_LANES, DATA_W, ACC_W)) begin : g_bad_cfg
    $error("dsp_mac_dotprod_acc: illegal NUM_LANES/DATA_W/ACC_W combination");
  end

  logic             en;
  logic             s2_valid, s2_clear, s2_last;
  logic [SW-1:0]    s2_sum;
  logic [63:0]      s_ext;
  sat_res_t         add;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             sat_q, sat_d;
  logic             fresh_q, fresh_d;
  logic             ovalid_q, ovalid_d;
  logic [ACC_W-1:0] result_q, result_d;
  logic             osat_q, osat_d;

  // The whole pipeline freezes while a result waits for the consumer.
  assign en     = !(ovalid_q && !iready);
  assign oready = en;

  dsp_mac_reduce #(
    .NUM_LANES (NUM_LANES),
    .DATA_W    (DATA_W),
    .SIGNED    (SIGNED),
    .SW        (SW)
  ) u_reduce (
    .clock   (clock),
    .resetn  (resetn),
    .en_i    (en),
    .valid_i (ivalid),
    .clear_i (iclear),
    .last_i  (ilast),
    .dataa_i (dataa),
    .datab_i (datab),
    .valid_o (s2_valid),
    .clear_o (s2_clear),
    .last_o  (s2_last),
    .sum_o   (s2_sum)
  );

  always_comb begin
    acc_d    = acc_q;
    sat_d    = sat_q;
    fresh_d  = fresh_q;
    ovalid_d = ovalid_q;
    result_d = result_q;
    osat_d   = osat_q;
    s_ext    = ext64(64'(s2_sum), SW, SIGNED);
    add      = sat_add(ext64(64'(acc_q), ACC_W, SIGNED), s_ext, ACC_W, SIGNED);
    if (en) begin
      // Not stalled: any held result has been taken this edge.
      ovalid_d = 1'b0;
      if (s2_valid) begin
        if (s2_clear || fresh_q) begin
          acc_d = ACC_W'(s_ext);
          sat_d = 1'b0;
        end else begin
          acc_d = ACC_W'(add.val);
          sat_d = sat_q | add.ovf;
        end
        fresh_d = s2_last;
        if (s2_last) begin
          ovalid_d = 1'b1;
          result_d = acc_d;
          osat_d   = sat_d;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      acc_q    <= '0;
      sat_q    <= 1'b0;
      fresh_q  <= 1'b1;
      ovalid_q <= 1'b0;
      result_q <= '0;
      osat_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      sat_q    <= sat_d;
      fresh_q  <= fresh_d;
      ovalid_q <= ovalid_d;
      result_q <= result_d;
      osat_q   <= osat_d;
    end
  end

  assign ovalid = ovalid_q;
  assign result = result_q;
  assign osat   = osat_q;

endmodule

// File: tb/tb_dsp_mac_dotprod_acc.sv
module tb_dsp_mac_dotprod_acc;

  logic        clock;
  logic        resetn;
  logic        ivalid;
  logic [31:0] dataa, datab;
  logic        iclear, ilast;
  logic        iready;

  logic        oready0, oready1, oready2;
  logic        ovalid0, ovalid1, ovalid2;
  logic [31:0] result0, result1;
  logic [17:0] result2;
  logic        osat0, osat1, osat2;

  int n_cmp  = 0;
  int n_fail = 0;
  bit rdy_cur = 1'b1;

  typedef struct {
    longint res;
    bit     sat;
  } exp_t;

  exp_t   q0[$], q1[$], q2[$];
  longint m_acc  [3];
  bit     m_sat  [3];
  bit     m_fresh[3];

  // 0: signed 32-bit, 1: unsigned 32-bit, 2: signed 18-bit
  dsp_mac_dotprod_acc #(.NUM_LANES(4), .DATA_W(8), .ACC_W(32), .SIGNED(1'b1)) u_dut (
    .clock(clock), .resetn(resetn), .ivalid(ivalid), .oready(oready0),
    .dataa(dataa), .datab(datab), .iclear(iclear), .ilast(ilast),
    .ovalid(ovalid0), .iready(iready), .result(result0), .osat(osat0));

  dsp_mac_dotprod_acc #(.NUM_LANES(4), .DATA_W(8), .ACC_W(32), .SIGNED(1'b0)) u_dut_uns (
    .clock(clock), .resetn(resetn), .ivalid(ivalid), .oready(oready1),
    .dataa(dataa), .datab(datab), .iclear(iclear), .ilast(ilast),
    .ovalid(ovalid1), .iready(iready), .result(result1), .osat(osat1));

  dsp_mac_dotprod_acc #(.NUM_LANES(4), .DATA_W(8), .ACC_W(18), .SIGNED(1'b1)) u_dut_sat (
    .clock(clock), .resetn(resetn), .ivalid(ivalid), .oready(oready2),
    .dataa(dataa), .datab(datab), .iclear(iclear), .ilast(ilast),
    .ovalid(ovalid2), .iready(iready), .result(result2), .osat(osat2));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack4(input int l0, input int l1, input int l2, input int l3);
    return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
  endfunction

  function automatic bit m_sgn(input int m);
    return m != 1;
  endfunction

  function automatic int m_w(input int m);
    return (m == 2) ? 18 : 32;
  endfunction

  function automatic longint dot(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    longint s;
    logic [7:0] x, y;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      x = a[8*i +: 8];
      y = b[8*i +: 8];
      if (sgn) s += longint'($signed(x)) * longint'($signed(y));
      else     s += longint'(x) * longint'(y);
    end
    return s;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 3; m++) begin
      m_acc[m]   = 0;
      m_sat[m]   = 1'b0;
      m_fresh[m] = 1'b1;
    end
    q0.delete();
    q1.delete();
    q2.delete();
  endtask

  task automatic model_accept(input logic [31:0] a, input logic [31:0] b, input bit c, input bit l);
    longint s, t, hi, lo;
    exp_t   e;
    for (int m = 0; m < 3; m++) begin
      s  = dot(a, b, m_sgn(m));
      hi = m_sgn(m) ? (longint'(1) << (m_w(m) - 1)) - 1 : (longint'(1) << m_w(m)) - 1;
      lo = m_sgn(m) ? -(longint'(1) << (m_w(m) - 1)) : 0;
      if (c || m_fresh[m]) begin
        m_acc[m] = s;
        m_sat[m] = 1'b0;
      end else begin
        t = m_acc[m] + s;
        if (t > hi) begin t = hi; m_sat[m] = 1'b1; end
        if (t < lo) begin t = lo; m_sat[m] = 1'b1; end
        m_acc[m] = t;
      end
      m_fresh[m] = l;
      if (l) begin
        e.res = m_acc[m];
        e.sat = m_sat[m];
        case (m)
          0:       q0.push_back(e);
          1:       q1.push_back(e);
          default: q2.push_back(e);
        endcase
      end
    end
  endtask

  task automatic pop_check(input int m, input logic [63:0] res, input logic sat);
    exp_t        e;
    int          sz;
    logic [63:0] mask;
    sz = (m == 0) ? q0.size() : (m == 1) ? q1.size() : q2.size();
    n_cmp++;
    assert (sz != 0) else begin
      n_fail++;
      $error("FAIL out%0d_unexpected: observed result %0h, expected no output", m, res);
    end
    if (sz != 0) begin
      case (m)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      mask = (64'd1 << m_w(m)) - 64'd1;
      chk($sformatf("result%0d", m), res, 64'(e.res) & mask);
      chk($sformatf("osat%0d", m), 64'(sat), 64'(e.sat));
    end
  endtask

  // Outputs sampled mid-low-phase; a transfer happens at the next rising edge.
  always @(negedge clock) begin
    #2;
    if (resetn && ovalid0 && iready) pop_check(0, 64'(result0), osat0);
    if (resetn && ovalid1 && iready) pop_check(1, 64'(result1), osat1);
    if (resetn && ovalid2 && iready) pop_check(2, 64'(result2), osat2);
  end

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit v, input logic [31:0] a, input logic [31:0] b,
                      input bit c, input bit l, input bit rdy, output bit took);
    ivalid = v;
    dataa  = a;
    datab  = b;
    iclear = c;
    ilast  = l;
    iready = rdy;
    #1;
    took = v && oready0;
    @(posedge clock);
    if (took) model_accept(a, b, c, l);
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    bit t;
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, rdy_cur, t);
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input bit c, input bit l);
    bit took;
    took = 1'b0;
    for (int n = 0; n < 50 && !took; n++) step(1'b1, a, b, c, l, rdy_cur, took);
    chk("send_accepted", 64'(took), 64'd1);
    ivalid = 1'b0;
  endtask

  logic [31:0] va, vb, vn128, vp127, vff;
  bit          took_s;

  initial begin
    va    = pack4(1, 2, 3, 4);
    vb    = pack4(5, 6, 7, 8);
    vn128 = pack4(-128, -128, -128, -128);
    vp127 = pack4(127, 127, 127, 127);
    vff   = pack4(255, 255, 255, 255);

    resetn = 1'b0;
    ivalid = 1'b0; dataa = '0; datab = '0; iclear = 1'b0; ilast = 1'b0; iready = 1'b1;
    model_reset();
    repeat (3) @(negedge clock);
    chk("rst_ovalid", 64'(ovalid0), 64'd0);
    chk("rst_result", 64'(result0), 64'd0);
    chk("rst_osat",   64'(osat0),   64'd0);
    chk("rst_oready", 64'({oready0, oready1, oready2}), 64'd7);
    resetn = 1'b1;
    idle(2);

    // single beat and its latency / one-cycle pulse
    send(va, vb, 1'b1, 1'b1);
    chk("lat_edge1", 64'(ovalid0), 64'd0);
    idle(1);
    chk("lat_edge2", 64'(ovalid0), 64'd0);
    idle(1);
    chk("lat_edge3", 64'(ovalid0), 64'd1);
    chk("lat_result", 64'(result0), 64'd70);
    idle(1);
    chk("pulse_one_cycle", 64'(ovalid0), 64'd0);
    idle(2);

    // extremes, back-to-back single-beat products
    send(vn128, vn128, 1'b1, 1'b1);
    send(vn128, vp127, 1'b1, 1'b1);
    send(vff,   vff,   1'b1, 1'b1);
    idle(5);

    // accumulate over three beats, then auto-fresh without iclear
    send(va, vb, 1'b1, 1'b0);
    send(va, vb, 1'b0, 1'b0);
    send(va, vb, 1'b0, 1'b1);
    send(va, vb, 1'b0, 1'b1);
    idle(5);

    // saturation on the 18-bit instance, then a clean accumulation
    send(vn128, vn128, 1'b1, 1'b0);
    send(vn128, vn128, 1'b0, 1'b1);
    send(va, vb, 1'b1, 1'b1);
    idle(5);

    // backpressure
    rdy_cur = 1'b0;
    send(va, vb, 1'b1, 1'b1);
    for (int n = 0; n < 10 && !ovalid0; n++) idle(1);
    chk("bp_ovalid_seen", 64'(ovalid0), 64'd1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, pack4(9, 9, 9, 9), vb, 1'b1, 1'b1, 1'b0, took_s);
      chk("bp_not_taken", 64'(took_s), 64'd0);
      chk("bp_oready",    64'({oready0, oready1, oready2}), 64'd0);
      chk("bp_ovalid",    64'(ovalid0), 64'd1);
      chk("bp_result",    64'(result0), 64'd70);
    end
    rdy_cur = 1'b1;
    idle(4);

    // streaming with toggling ivalid and iready
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, $urandom,
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) != 0), took_s);
    end
    ivalid = 1'b0;
    idle(8);

    // reset mid-accumulation with a result just presented
    send(va, vb, 1'b1, 1'b1);
    send(va, vb, 1'b1, 1'b0);
    send(va, vb, 1'b0, 1'b0);
    resetn = 1'b0;
    model_reset();
    #1;
    chk("rst_mid_ovalid", 64'(ovalid0), 64'd0);
    chk("rst_mid_result", 64'(result0), 64'd0);
    @(negedge clock);
    resetn = 1'b1;
    idle(1);
    send(va, vb, 1'b0, 1'b1);
    idle(6);

    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    chk("q2_drained", 64'(q2.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
